// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM address and
// registers the fetched word into the IF/ID boundary for the Control Unit.
module fetch_stage #(
  parameter int unsigned        PC_W     = 8,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic               clk,
  input  logic               R,
  input  logic               LE,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic               id_valid,
  output logic               misaligned,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_id_instr;
  logic [PC_W-1:0]    r_id_pc;
  logic [PC_W-1:0]    r_id_pc_plus4;
  logic               r_id_valid;
  logic               r_misaligned;
  logic [CNT_W-1:0]   r_fetch_count;

  logic [PC_W-1:0]    w_pc_plus4;
  logic [PC_W-1:0]    w_target;
  logic               w_target_misaligned;
  logic               w_cnt_sat;

  // Redirect targets are forced word-aligned; low bits only raise the sticky flag.
  assign w_pc_plus4          = r_pc + PC_W'(4);
  assign w_target            = {branch_target[PC_W-1:2], 2'b00};
  assign w_target_misaligned = |branch_target[1:0];
  assign w_cnt_sat           = &r_fetch_count;

  // Priority: branch redirect (inserts a bubble) > advance > hold.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_pc          <= RESET_PC;
      r_id_instr    <= NOP_WORD;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_valid    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else if (branch_taken) begin
      r_pc       <= w_target;
      r_id_instr <= NOP_WORD;
      r_id_valid <= 1'b0;
      if (w_target_misaligned) begin
        r_misaligned <= 1'b1;
      end
    end else if (LE) begin
      r_pc          <= w_pc_plus4;
      r_id_instr    <= rom_instr;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      if (!w_cnt_sat) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end
    end
  end

  assign rom_addr    = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, a word-level model of
// the fetch rules, and a second instance with a 3-bit counter for saturation.
module tb_fetch_stage;

  logic        clk;
  logic        R;
  logic        LE;
  logic        branch_taken;
  logic [7:0]  branch_target;

  logic [7:0]  rom_addr_a,    rom_addr_b;
  logic [31:0] rom_instr_a,   rom_instr_b;
  logic [31:0] id_instr_a,    id_instr_b;
  logic [7:0]  id_pc_a,       id_pc_b;
  logic [7:0]  id_pc_plus4_a, id_pc_plus4_b;
  logic        id_valid_a,    id_valid_b;
  logic        misaligned_a,  misaligned_b;
  logic [15:0] fetch_count_a;
  logic [2:0]  fetch_count_b;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // ROM: word n holds E000_0000 + n.
  assign rom_instr_a = 32'hE000_0000 + 32'(rom_addr_a[7:2]);
  assign rom_instr_b = 32'hE000_0000 + 32'(rom_addr_b[7:2]);

  fetch_stage #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00), .NOP_WORD(32'h0), .CNT_W(16)) u_dut (
    .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_addr(rom_addr_a), .rom_instr(rom_instr_a), .id_instr(id_instr_a), .id_pc(id_pc_a),
    .id_pc_plus4(id_pc_plus4_a), .id_valid(id_valid_a), .misaligned(misaligned_a),
    .fetch_count(fetch_count_a)
  );

  fetch_stage #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00), .NOP_WORD(32'h0), .CNT_W(3)) u_dut_sat (
    .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_addr(rom_addr_b), .rom_instr(rom_instr_b), .id_instr(id_instr_b), .id_pc(id_pc_b),
    .id_pc_plus4(id_pc_plus4_b), .id_valid(id_valid_b), .misaligned(misaligned_b),
    .fetch_count(fetch_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: addresses as plain integers, loads counted without bound.
  int m_pc, m_id_pc, m_id_plus4, m_loads;
  logic [31:0] m_instr;
  bit m_valid, m_mis;

  always @(posedge clk or posedge R) begin
    if (R) begin
      m_pc <= 0; m_id_pc <= 0; m_id_plus4 <= 0; m_loads <= 0;
      m_instr <= 32'h0; m_valid <= 1'b0; m_mis <= 1'b0;
    end else if (branch_taken) begin
      m_pc    <= int'(branch_target) - (int'(branch_target) % 4);
      m_instr <= 32'h0;
      m_valid <= 1'b0;
      if (int'(branch_target) % 4 != 0) m_mis <= 1'b1;
    end else if (LE) begin
      m_instr    <= 32'hE000_0000 + 32'(m_pc / 4);
      m_id_pc    <= m_pc;
      m_id_plus4 <= (m_pc + 4) % 256;
      m_pc       <= (m_pc + 4) % 256;
      m_valid    <= 1'b1;
      m_loads    <= m_loads + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("rom_addr",    32'(rom_addr_a),    32'(m_pc));
      check("id_instr",    id_instr_a,         m_instr);
      check("id_pc",       32'(id_pc_a),       32'(m_id_pc));
      check("id_pc_plus4", 32'(id_pc_plus4_a), 32'(m_id_plus4));
      check("id_valid",    32'(id_valid_a),    32'(m_valid));
      check("misaligned",  32'(misaligned_a),  32'(m_mis));
      check("fetch_count", 32'(fetch_count_a), 32'((m_loads > 65535) ? 65535 : m_loads));
      check("sat_rom_addr",    32'(rom_addr_b),    32'(m_pc));
      check("sat_fetch_count", 32'(fetch_count_b), 32'((m_loads > 7) ? 7 : m_loads));
    end
  end

  // One clock with the given inputs; returns just after the following falling edge.
  task automatic cyc(input logic le, input logic bt, input logic [7:0] tgt);
    LE = le; branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset raised between edges, observed before the next rising edge.
  task automatic mid_reset();
    #2 R = 1'b1;
    #1;
    check("async_rst_pc",    32'(rom_addr_a),    32'h0);
    check("async_rst_valid", 32'(id_valid_a),    32'h0);
    check("async_rst_cnt",   32'(fetch_count_a), 32'h0);
    check("async_rst_cnt3",  32'(fetch_count_b), 32'h0);
    check("async_rst_mis",   32'(misaligned_a),  32'h0);
    @(negedge clk);
    R = 1'b0;
  endtask

  initial begin
    R = 1'b0; LE = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    #1 R = 1'b1;
    repeat (2) @(negedge clk);
    R = 1'b0;
    check_en = 1'b1;
    check("reset_instr", id_instr_a,         32'h0);
    check("reset_valid", 32'(id_valid_a),    32'h0);
    check("reset_cnt",   32'(fetch_count_a), 32'h0);

    // Straight-line fetch of four words.
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    check("t1_addr",  32'(rom_addr_a),    32'h10);
    check("t1_instr", id_instr_a,         32'hE000_0003);
    check("t1_pc",    32'(id_pc_a),       32'h0C);
    check("t1_plus4", 32'(id_pc_plus4_a), 32'h10);
    check("t1_cnt",   32'(fetch_count_a), 32'd4);

    // Stall at pc=8 for three edges, then resume.
    mid_reset();
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check("t2_addr",  32'(rom_addr_a),    32'h08);
    check("t2_instr", id_instr_a,         32'hE000_0001);
    check("t2_pc",    32'(id_pc_a),       32'h04);
    check("t2_cnt",   32'(fetch_count_a), 32'd2);
    cyc(1'b1, 1'b0, 8'h00);
    check("t2_resume", id_instr_a,      32'hE000_0002);
    check("t2_rpc",    32'(id_pc_a),    32'h08);

    // Branch from pc=12 to 0x40: bubble, then target instruction.
    cyc(1'b1, 1'b1, 8'h40);
    check("t3_addr",  32'(rom_addr_a), 32'h40);
    check("t3_instr", id_instr_a,      32'h0);
    check("t3_valid", 32'(id_valid_a), 32'h0);
    cyc(1'b1, 1'b0, 8'h00);
    check("t3_tpc",   32'(id_pc_a),       32'h40);
    check("t3_tins",  id_instr_a,         32'hE000_0010);
    check("t3_tval",  32'(id_valid_a),    32'h1);
    check("t3_cnt",   32'(fetch_count_a), 32'd4);

    // Branch while stalled still redirects and inserts a bubble.
    cyc(1'b0, 1'b1, 8'h20);
    check("t4_addr",  32'(rom_addr_a), 32'h20);
    check("t4_valid", 32'(id_valid_a), 32'h0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    check("t4_tpc",   32'(id_pc_a), 32'h20);

    // PC wrap at 0xFC, then a misaligned target.
    cyc(1'b1, 1'b1, 8'hFC);
    cyc(1'b1, 1'b0, 8'h00);
    check("t5_wrap_addr",  32'(rom_addr_a),    32'h00);
    check("t5_wrap_pc",    32'(id_pc_a),       32'hFC);
    check("t5_wrap_plus4", 32'(id_pc_plus4_a), 32'h00);
    cyc(1'b1, 1'b1, 8'h23);
    check("t5_mis_addr", 32'(rom_addr_a),   32'h20);
    check("t5_mis",      32'(misaligned_a), 32'h1);
    for (int i = 0; i < 10; i++) cyc(1'(i % 2), 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h40);
    check("t5_sticky", 32'(misaligned_a), 32'h1);

    // Saturation of the 3-bit counter, then asynchronous reset mid-cycle.
    mid_reset();
    repeat (9) cyc(1'b1, 1'b0, 8'h00);
    check("t6_cnt3", 32'(fetch_count_b), 32'd7);
    check("t6_cnt",  32'(fetch_count_a), 32'd9);
    check("t6_addr", 32'(rom_addr_a),    32'h24);
    cyc(1'b1, 1'b0, 8'h00);
    check("t6_hold3", 32'(fetch_count_b), 32'd7);
    LE = 1'b1;
    mid_reset();
    check("t6_after_rst_addr", 32'(rom_addr_a), 32'h00);
    cyc(1'b1, 1'b0, 8'h00);
    check("t6_restart_cnt",   32'(fetch_count_a), 32'd1);
    check("t6_restart_instr", id_instr_a,         32'hE000_0000);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
